// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, ALU/mux encodings and FSM states for the multi-cycle control unit
package multicycle_control_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, HALT
    } state_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bundle between the control FSM and the datapath/memory
// master (control FSM): in opcode, memReady; out memory request, mux selects, write strobes, aluOp, illegal
// slave (datapath): the mirror image
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       memReady;
    logic       memReq;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       irWrite;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcSource;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       memToReg;
    logic       regWrite;
    logic       illegal;
    modport master (
        input  opcode, memReady,
        output memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, pcSource,
               aluSrcA, aluSrcB, aluOp, memToReg, regWrite, illegal
    );
    modport slave (
        output opcode, memReady,
        input  memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, pcSource,
               aluSrcA, aluSrcB, aluOp, memToReg, regWrite, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle RV32I-subset datapath (lw, sw, beq, R-type)
// clk, rst_n (async active-low); bus: opcode/memReady in, selects/strobes/aluOp/illegal out; retired: completed-instruction count
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus,
    output logic [CNT_W-1:0]     retired
);
    state_t state, next;
    logic   retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state   <= next;
            retired <= retire ? retired + 1'b1 : retired;
        end
    end

    always_comb begin
        next            = state;
        retire          = 1'b0;
        bus.memReq      = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.iorD        = 1'b0;
        bus.irWrite     = 1'b0;
        bus.pcWrite     = 1'b0;
        bus.pcWriteCond = 1'b0;
        bus.pcSource    = 1'b0;
        bus.aluSrcA     = 1'b0;
        bus.aluSrcB     = SRCB_RS2;
        bus.aluOp       = ALUOP_ADD;
        bus.memToReg    = 1'b0;
        bus.regWrite    = 1'b0;
        bus.illegal     = 1'b0;
        case (state)
            FETCH: begin
                bus.memReq  = 1'b1;
                bus.memRead = 1'b1;
                bus.aluSrcB = SRCB_FOUR;
                bus.irWrite = bus.memReady;
                bus.pcWrite = bus.memReady;
                next        = bus.memReady ? DECODE : FETCH;
            end
            DECODE: begin
                bus.aluSrcB = SRCB_IMM;
                next = (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) ? MEM_ADDR :
                       bus.opcode == OP_RTYPE  ? EXECUTE :
                       bus.opcode == OP_BRANCH ? BRANCH : HALT;
            end
            MEM_ADDR: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = SRCB_IMM;
                next        = bus.opcode == OP_LOAD ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                bus.memReq  = 1'b1;
                bus.memRead = 1'b1;
                bus.iorD    = 1'b1;
                next        = bus.memReady ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                bus.regWrite = 1'b1;
                bus.memToReg = 1'b1;
                retire       = 1'b1;
                next         = FETCH;
            end
            MEM_WRITE: begin
                bus.memReq   = 1'b1;
                bus.memWrite = 1'b1;
                bus.iorD     = 1'b1;
                retire       = bus.memReady;
                next         = bus.memReady ? FETCH : MEM_WRITE;
            end
            EXECUTE: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = ALUOP_FUNCT;
                next        = ALU_WB;
            end
            ALU_WB: begin
                bus.regWrite = 1'b1;
                retire       = 1'b1;
                next         = FETCH;
            end
            BRANCH: begin
                bus.aluSrcA     = 1'b1;
                bus.aluOp       = ALUOP_SUB;
                bus.pcWriteCond = 1'b1;
                bus.pcSource    = 1'b1;
                retire          = 1'b1;
                next            = FETCH;
            end
            HALT: bus.illegal = 1'b1;
            default: next = FETCH;
        endcase
        // The state register resets to FETCH, whose decode would request memory; mask everything while in reset.
        if (!rst_n) begin
            bus.memReq      = 1'b0;
            bus.memRead     = 1'b0;
            bus.memWrite    = 1'b0;
            bus.iorD        = 1'b0;
            bus.irWrite     = 1'b0;
            bus.pcWrite     = 1'b0;
            bus.pcWriteCond = 1'b0;
            bus.pcSource    = 1'b0;
            bus.aluSrcA     = 1'b0;
            bus.aluSrcB     = SRCB_RS2;
            bus.aluOp       = ALUOP_ADD;
            bus.memToReg    = 1'b0;
            bus.regWrite    = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized scoreboard bench for multicycle_control with a latency-level reference model
module tb_multicycle_control;
    localparam int K_LW = 0, K_SW = 1, K_ALU = 2, K_BEQ = 3, K_ILL = 4;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, BEQ = 7'b1100011;

    typedef struct { logic [6:0] op; int df; int dd; } instr_t;
    typedef struct { int kind; int cyc; int ret; } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] retired;
    int         checks = 0, errors = 0, gcyc = 0, mret = 0;
    instr_t     prog[$];
    exp_t       exq[$];

    multicycle_control_if bus();
    multicycle_control #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .retired(retired));

    always #5 clk = ~clk;
    always @(posedge clk) gcyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, gcyc);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.memReq, bus.memRead, bus.memWrite, bus.irWrite, bus.pcWrite, bus.pcWriteCond, bus.regWrite};
    endfunction

    function automatic logic [7:0] selects();
        return {bus.iorD, bus.pcSource, bus.aluSrcA, bus.aluSrcB, bus.aluOp, bus.memToReg};
    endfunction

    // Reference model: instruction class and cycle count straight from the published latencies plus memory waits.
    function automatic exp_t model(instr_t i, int issue, int ret);
        exp_t e;
        e.ret = ret;
        case (i.op)
            LW:      begin e.kind = K_LW;  e.cyc = issue + 5 + i.df + i.dd - 1; end
            SW:      begin e.kind = K_SW;  e.cyc = issue + 4 + i.df + i.dd - 1; end
            RT:      begin e.kind = K_ALU; e.cyc = issue + 4 + i.df - 1; end
            BEQ:     begin e.kind = K_BEQ; e.cyc = issue + 3 + i.df - 1; end
            default: begin e.kind = K_ILL; e.cyc = issue + 3 + i.df - 1; end
        endcase
        return e;
    endfunction

    // Memory model: each access waits its programmed number of cycles; a fetch issues the next instruction.
    instr_t cur;
    bit     busy = 0;
    int     wcnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.memReady = 1'b0;
            busy = 0;
        end else begin
            if (bus.memReq && !busy && (bus.iorD || prog.size() != 0)) begin
                busy = 1;
                if (!bus.iorD) begin
                    cur = prog.pop_front();
                    bus.opcode = cur.op;
                    wcnt = cur.df;
                    exq.push_back(model(cur, gcyc, mret));
                    if (cur.op inside {LW, SW, RT, BEQ}) mret = (mret + 1) % 16;
                end else wcnt = cur.dd;
            end
            if (busy && wcnt == 0) begin
                bus.memReady = 1'b1;
                busy = 0;
            end else begin
                bus.memReady = 1'b0;
                if (busy) wcnt--;
            end
        end
    end

    // Monitor: pops one expectation per retirement (or HALT entry) and checks handshake stability.
    int irw = 0, pcw = 0, kind;
    bit seen_ill = 0, prev_req = 0, prev_rdy = 0, prev_rd = 0, prev_wr = 0, prev_iord = 0;
    logic [1:0] prev_aluop = 2'b00;
    exp_t e;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            chk("rst_strobes", {25'd0, strobes()}, 32'd0);
            irw = 0; pcw = 0; seen_ill = 0; prev_req = 0;
        end else begin
            irw += int'(bus.irWrite);
            pcw += int'(bus.pcWrite);
            if (prev_req && !prev_rdy)
                chk("req_hold", {bus.memReq, bus.memRead, bus.memWrite, bus.iorD}, {1'b1, prev_rd, prev_wr, prev_iord});
            kind = bus.illegal ? (seen_ill ? -1 : K_ILL) :
                   bus.regWrite ? (bus.memToReg ? K_LW : K_ALU) :
                   (bus.memWrite && bus.memReady) ? K_SW :
                   bus.pcWriteCond ? K_BEQ : -1;
            if (bus.illegal && seen_ill) chk("halt_quiet", {25'd0, strobes()}, 32'd0);
            if (kind >= 0) begin
                if (exq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty actual=kind%0d required=none (cycle %0d)", kind, gcyc);
                end else begin
                    e = exq.pop_front();
                    chk("kind", kind, e.kind);
                    chk("latency", gcyc, e.cyc);
                    chk("fetch_pulses", {irw[15:0], pcw[15:0]}, {16'd1, 16'd1});
                    if (kind == K_ILL) seen_ill = 1;
                    else begin
                        chk("retired", {28'd0, retired}, e.ret);
                        chk("ctl", {bus.regWrite, bus.memToReg, bus.pcWriteCond, bus.memWrite, bus.pcWrite,
                                    bus.pcSource, bus.aluOp, prev_aluop},
                            kind == K_LW  ? 10'b1100_00_00_00 :
                            kind == K_ALU ? 10'b1000_00_00_10 :
                            kind == K_SW  ? 10'b0001_00_00_00 : 10'b0010_01_01_00);
                    end
                end
                irw = 0; pcw = 0;
            end
            prev_req = bus.memReq; prev_rdy = bus.memReady; prev_rd = bus.memRead;
            prev_wr = bus.memWrite; prev_iord = bus.iorD;
        end
        prev_aluop = bus.aluOp;
    end

    task automatic drain();
        int n = 0;
        while ((prog.size() != 0 || exq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0", prog.size(), exq.size());
        end
        @(negedge clk);
        #2;
        chk("retired_idle", {28'd0, retired}, mret);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", {17'd0, strobes(), selects()}, 32'd0);
        prog.delete(); exq.delete(); mret = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_retired", {28'd0, retired}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bus.opcode = 7'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_retired", {28'd0, retired}, 32'd0);
        chk("init_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("init_outputs", {17'd0, strobes(), selects()}, 32'd0);
        rst_n = 1'b1;
        prog.push_back('{LW, 2, 2});
        prog.push_back('{SW, 0, 0});
        prog.push_back('{RT, 0, 0});
        prog.push_back('{BEQ, 0, 0});
        drain();
        for (int i = 0; i < 40; i++) begin
            instr_t r;
            case ($urandom_range(0, 3))
                0: r.op = LW;
                1: r.op = SW;
                2: r.op = RT;
                default: r.op = BEQ;
            endcase
            r.df = $urandom_range(0, 2);
            r.dd = $urandom_range(0, 2);
            prog.push_back(r);
        end
        drain();
        do_reset();
        for (int i = 0; i < 17; i++) prog.push_back('{RT, 0, 0});
        drain();
        chk("wrap_count", {28'd0, retired}, 32'd1);
        prog.push_back('{7'b0010011, 1, 0});
        drain();
        repeat (4) @(negedge clk);
        #1 chk("halt_sticky", {31'd0, bus.illegal}, 32'd1);
        do_reset();
        prog.push_back('{LW, 0, 6});
        n = 0;
        do begin
            @(negedge clk);
            #1 n++;
        end while (!(bus.memReq && bus.iorD && bus.memRead) && n < 200);
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL mem_read_timeout actual=%0d cycles required=<200", n);
        end
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_access", {17'd0, strobes(), selects()}, 32'd0);
        prog.delete(); exq.delete(); mret = 0;
        repeat (2) @(posedge clk);
        #1 chk("rst_mid_retired", {28'd0, retired}, 32'd0);
        rst_n = 1'b1;
        prog.push_back('{RT, 1, 0});
        prog.push_back('{SW, 1, 1});
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
